// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time byte-stream loader that fills instruction memory and releases the core.
// Optional trailing XOR checksum byte is enabled with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   In_Valid,
  input  logic [7:0]             In_Data,
  output logic                   In_Ready,
  output logic                   Mem_We,
  output logic [ADDR_WIDTH-1:0]  Mem_Addr,
  output logic [INSTR_WIDTH-1:0] Mem_Data,
  output logic                   Core_Rst,
  output logic                   Done,
  output logic                   Error
);

  localparam int BYTES = INSTR_WIDTH / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, FINISH, DONE, ERR, CHK} state_t;
`else
  typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, FINISH, DONE, ERR} state_t;
`endif

  state_t                  state, next_state;
  logic [15:0]             count;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [BW-1:0]           byte_idx;
  logic [INSTR_WIDTH-1:0]  word_reg;
  logic [INSTR_WIDTH-1:0]  word_next;
  logic [15:0]             count_in;
  logic                    count_bad;
  logic                    last_byte;
  logic                    last_word;
  logic                    ready;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]              csum;
`endif

  assign word_next = (word_reg << 8) | INSTR_WIDTH'(In_Data);
  assign count_in  = {count[15:8], In_Data};
  assign count_bad = (count_in == 16'd0) || (32'(count_in) > (32'd1 << ADDR_WIDTH));
  assign last_byte = (byte_idx == BW'(BYTES - 1));
  assign last_word = (32'(word_idx) == 32'(count) - 32'd1);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= CNT_HI;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    Done       = 1'b0;
    Error      = 1'b0;
    Core_Rst   = 1'b1;
    case (state)
      CNT_HI: begin
        ready = 1'b1;
        if (In_Valid) next_state = CNT_LO;
      end
      CNT_LO: begin
        ready = 1'b1;
        if (In_Valid) next_state = count_bad ? ERR : DATA;
      end
      DATA: begin
        ready = 1'b1;
        if (In_Valid && last_byte && last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          next_state = CHK;
`else
          next_state = FINISH;
`endif
        end
      end
      FINISH: next_state = DONE;
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        ready = 1'b1;
        if (In_Valid) next_state = (csum == In_Data) ? DONE : ERR;
      end
`endif
      DONE: begin
        Done     = 1'b1;
        Core_Rst = 1'b0;
      end
      ERR: Error = 1'b1;
      default: next_state = ERR;
    endcase
    In_Ready = ready && !Rst;
  end

  // The write for a completed word is registered, so it lands one cycle after its last byte.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_reg <= '0;
      Mem_We   <= 1'b0;
      Mem_Addr <= '0;
      Mem_Data <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      Mem_We <= 1'b0;
      case (state)
        CNT_HI: begin
          if (In_Valid) count[15:8] <= In_Data;
        end
        CNT_LO: begin
          if (In_Valid) count[7:0] <= In_Data;
          word_idx <= '0;
          byte_idx <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum     <= '0;
`endif
        end
        DATA: begin
          if (In_Valid) begin
            word_reg <= word_next;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= csum ^ In_Data;
`endif
            if (last_byte) begin
              Mem_We   <= 1'b1;
              Mem_Addr <= word_idx;
              Mem_Data <= word_next;
              word_idx <= word_idx + 1'b1;
              byte_idx <= '0;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
